// File: rtl/upsample_2x2_pkg.sv
// Shared types for the 2x2 nearest-neighbour upsampler.
package upsample_2x2_pkg;
  typedef enum logic [1:0] {IDLE, FIRST, SECOND} type_upsample_state_t;
endpackage

// File: rtl/upsample_2x2_pix.sv
// Horizontal pixel duplication: every input pixel fills two adjacent output slots.
module pix_dup #(
  parameter int C = 2,
  parameter int W = 8
) (
  input  logic [C-1:0][W-1:0]   i_row,
  output logic [2*C-1:0][W-1:0] o_row
);
  for (genvar c = 0; c < C; c++) begin : g_dup
    assign o_row[2*c]   = i_row[c];
    assign o_row[2*c+1] = i_row[c];
  end
endmodule

// File: rtl/upsample_2x2.sv
// Streaming 2x2 nearest-neighbour upsampler: each input row is emitted twice,
// horizontally doubled, with a one-entry skid buffer to keep full throughput.
module upsample_2x2
  import upsample_2x2_pkg::*;
#(
  parameter int C = 2,
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [C-1:0][W-1:0]    s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [2*C-1:0][W-1:0]  m_data,
  output logic                   m_dup
);
  type_upsample_state_t r_state, w_state_nxt;
  logic [C-1:0][W-1:0] r_out_row, r_pend_row;
  logic                r_pend_v;
  logic                w_accept, w_load_s, w_load_pend, w_wr_pend;

  // Ready depends only on registered state so no path exists from m_ready.
  assign s_ready  = !rst && !r_pend_v;
  assign w_accept = s_valid && s_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_load_s    = 1'b0;
    w_load_pend = 1'b0;
    w_wr_pend   = 1'b0;
    m_valid     = 1'b0;
    m_dup       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_load_s    = 1'b1;
          w_state_nxt = FIRST;
        end
      end
      FIRST: begin
        m_valid   = 1'b1;
        w_wr_pend = w_accept;
        if (m_ready) w_state_nxt = SECOND;
      end
      SECOND: begin
        m_valid = 1'b1;
        m_dup   = 1'b1;
        if (m_ready) begin
          if (r_pend_v) begin
            w_load_pend = 1'b1;
            w_state_nxt = FIRST;
          end else if (w_accept) begin
            w_load_s    = 1'b1;
            w_state_nxt = FIRST;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_wr_pend = w_accept;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_out_row  <= '0;
      r_pend_row <= '0;
      r_pend_v   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_s)         r_out_row <= s_data;
      else if (w_load_pend) r_out_row <= r_pend_row;
      if (w_wr_pend) begin
        r_pend_row <= s_data;
        r_pend_v   <= 1'b1;
      end else if (w_load_pend) begin
        r_pend_v   <= 1'b0;
      end
    end
  end

  pix_dup #(.C(C), .W(W)) u_pix_dup (
    .i_row (r_out_row),
    .o_row (m_data)
  );
endmodule

// File: tb/tb_upsample_2x2.sv
// Scoreboard bench for upsample_2x2 (C=2/W=8 main instance, C=4/W=16 sweep instance).
module tb_upsample_2x2;
  logic clk, rst;
  logic s_valid, s_ready, m_valid, m_ready, m_dup;
  logic [1:0][7:0] s_data;
  logic [3:0][7:0] m_data;
  logic sw_valid, sw_ready, mw_valid, mw_ready, mw_dup;
  logic [3:0][15:0] sw_data;
  logic [7:0][15:0] mw_data;

  int n_chk, n_fail, n_in, n_out;
  logic [32:0] sb[$];
  logic        prev_stall;
  logic [31:0] prev_data;
  logic        prev_dup;

  upsample_2x2 #(.C(2), .W(8)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_dup(m_dup)
  );

  upsample_2x2 #(.C(4), .W(16)) dut_w (
    .clk(clk), .rst(rst), .s_valid(sw_valid), .s_ready(sw_ready), .s_data(sw_data),
    .m_valid(mw_valid), .m_ready(mw_ready), .m_data(mw_data), .m_dup(mw_dup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] dup2(input logic [15:0] d);
    return {d[15:8], d[15:8], d[7:0], d[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    m_ready = 1'b1;
    for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
    chk("drain", 128'(sb.size()), 128'd0);
  endtask

  // Monitor: push on accept, pop on output handshake, check hold under stall.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 128'(m_valid), 128'd1);
        chk("hold_data", 128'(m_data), 128'(prev_data));
        chk("hold_dup", 128'(m_dup), 128'(prev_dup));
      end
      if (s_valid && s_ready) begin
        sb.push_back({1'b0, dup2(s_data)});
        sb.push_back({1'b1, dup2(s_data)});
        n_in++;
      end
      if (m_valid && m_ready) begin
        n_out++;
        if (sb.size() == 0) chk("sb_empty", 128'd0, 128'd1);
        else chk("sb_beat", 128'({m_dup, m_data}), 128'(sb.pop_front()));
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_dup   = m_dup;
    end
  end

  initial begin
    logic [15:0] rows [3];
    logic        pat  [6];
    int          idx;
    logic        acc;
    n_chk = 0; n_fail = 0; n_in = 0; n_out = 0;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    sw_valid = 1'b0; sw_data = '0; mw_ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 128'(m_valid), 128'd0);
    chk("rst_dup", 128'(m_dup), 128'd0);
    chk("rst_data", 128'(m_data), 128'd0);
    chk("rst_sready", 128'(s_ready), 128'd0);
    rst = 1'b0;
    #1;
    chk("rst_sready_after", 128'(s_ready), 128'd1);

    // Single row
    m_ready = 1'b1; s_valid = 1'b1; s_data = 16'h1234;
    tick();
    s_valid = 1'b0;
    chk("one_v0", 128'(m_valid), 128'd1);
    chk("one_d0", 128'(m_data), 128'h12123434);
    chk("one_dup0", 128'(m_dup), 128'd0);
    tick();
    chk("one_v1", 128'(m_valid), 128'd1);
    chk("one_d1", 128'(m_data), 128'h12123434);
    chk("one_dup1", 128'(m_dup), 128'd1);
    tick();
    chk("one_idle", 128'(m_valid), 128'd0);

    // Back-to-back
    rows[0] = 16'h0102; rows[1] = 16'h0304; rows[2] = 16'h0506;
    pat[0] = 1; pat[1] = 1; pat[2] = 0; pat[3] = 1; pat[4] = 0; pat[5] = 1;
    idx = 0; s_valid = 1'b1; s_data = rows[0];
    for (int i = 0; i < 6; i++) begin
      chk("b2b_sready", 128'(s_ready), 128'(pat[i]));
      acc = s_valid && s_ready;
      tick();
      if (acc) idx++;
      if (idx < 3) s_data = rows[idx];
      else s_valid = 1'b0;
      chk("b2b_nogap", 128'(m_valid), 128'd1);
    end
    tick();
    chk("b2b_idle", 128'(m_valid), 128'd0);

    // Backpressure in FIRST
    m_ready = 1'b0; s_valid = 1'b1; s_data = 16'hAABB;
    tick();
    s_data = 16'hCCDD;
    chk("bp_sready_pre", 128'(s_ready), 128'd1);
    tick();
    s_valid = 1'b0;
    chk("bp_sready_full", 128'(s_ready), 128'd0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", 128'(m_data), 128'hAAAABBBB);
      chk("bp_dup", 128'(m_dup), 128'd0);
      tick();
    end
    drain();

    // Backpressure in SECOND with pend full
    m_ready = 1'b0; s_valid = 1'b1; s_data = 16'h5566;
    tick();
    s_data = 16'h7788;
    tick();
    s_valid = 1'b0; m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("s2_dup", 128'(m_dup), 128'd1);
    chk("s2_sready_a", 128'(s_ready), 128'd0);
    tick();
    m_ready = 1'b1;
    chk("s2_sready_b", 128'(s_ready), 128'd0);
    tick();
    m_ready = 1'b0;
    chk("s2_sready_c", 128'(s_ready), 128'd1);
    chk("s2_dup_y", 128'(m_dup), 128'd0);
    chk("s2_data_y", 128'(m_data), 128'h77778888);
    tick();
    m_ready = 1'b1; tick();
    m_ready = 1'b0; tick();
    m_ready = 1'b1; tick();
    drain();
    chk("beat_count", 128'(n_out), 128'(2 * n_in));

    // Reset during SECOND with pend occupied
    m_ready = 1'b0; s_valid = 1'b1; s_data = 16'h1357;
    tick();
    s_data = 16'h2468;
    tick();
    s_valid = 1'b0; m_ready = 1'b1;
    tick();
    chk("mr_dup_pre", 128'(m_dup), 128'd1);
    m_ready = 1'b0; rst = 1'b1;
    tick();
    chk("mr_valid", 128'(m_valid), 128'd0);
    chk("mr_dup", 128'(m_dup), 128'd0);
    chk("mr_data", 128'(m_data), 128'd0);
    chk("mr_sready_rst", 128'(s_ready), 128'd0);
    rst = 1'b0;
    #1;
    chk("mr_sready", 128'(s_ready), 128'd1);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("mr_no_emit", 128'(m_valid), 128'd0);
      tick();
    end

    // Wide instance: C=4, W=16
    sw_data = {16'hFFFF, 16'h0000, 16'h8001, 16'h7FFE};
    sw_valid = 1'b1;
    chk("w_sready", 128'(sw_ready), 128'd1);
    tick();
    sw_valid = 1'b0;
    chk("w_v0", 128'(mw_valid), 128'd1);
    chk("w_d0", 128'(mw_data), 128'hFFFF_FFFF_0000_0000_8001_8001_7FFE_7FFE);
    chk("w_dup0", 128'(mw_dup), 128'd0);
    tick();
    chk("w_d1", 128'(mw_data), 128'hFFFF_FFFF_0000_0000_8001_8001_7FFE_7FFE);
    chk("w_dup1", 128'(mw_dup), 128'd1);
    tick();
    chk("w_idle", 128'(mw_valid), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/upsample_2x2.md
Name: upsample_2x2

Overview:
- Streaming 2x2 nearest-neighbour upsampler; the inverse of the 2x2 max-pool stage on the same valid/ready pixel-row stream.
- Accepts one row of C pixels per input beat.
- Emits two output beats per input row, each 2C pixels wide, with every input pixel duplicated horizontally.
- Sits in the decoder/expansion path, fed by a pooled feature stream and driving a downstream stage of twice the row width.

Parameters:
- C, 2, input pixels per row (output row is 2C).
- W, 8, bits per pixel (unsigned, passed through unmodified).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input row valid.
- s_ready  out  1  input row accepted when s_valid && s_ready.
- s_data  in  C x W (packed [C-1:0][W-1:0])  input row.
- m_valid  out  1  output row valid.
- m_ready  in  1  downstream ready.
- m_data  out  2C x W (packed [2C-1:0][W-1:0])  output row.
- m_dup  out  1  0 on first copy of a row, 1 on second copy.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high, sampled on the rising edge of clk.
- Reset values: m_valid=0, m_dup=0, m_data=0, pending buffer empty, state IDLE.
- s_ready is 0 while rst=1. A reset mid-row discards the current and pending rows with no partial output.
- Storage is registered:
  - output register out_row (C x W) plus phase;
  - one-entry pending buffer pend_row/pend_v.
- m_data mapping: m_data[2c] = m_data[2c+1] = out_row[c] for c in 0..C-1.
- s_ready = !rst && !pend_v. It is a registered-state function only, with no combinational path from m_ready.
- States (shared enum):
  - IDLE: m_valid=0.
  - FIRST: m_valid=1, m_dup=0.
  - SECOND: m_valid=1, m_dup=1.
- Transitions, evaluated each cycle:
  - IDLE + accept -> load s_data into out_row, go to FIRST.
  - FIRST + m_ready -> SECOND. An accept in the same cycle writes pend_row and sets pend_v.
  - FIRST without m_ready -> hold all outputs stable. An accept writes pend.
  - SECOND + m_ready with pend_v -> out_row<=pend_row, go to FIRST, pend_v<=0. No accept is possible because s_ready=0.
  - SECOND + m_ready with !pend_v and accept -> out_row<=s_data, go to FIRST.
  - SECOND + m_ready with !pend_v and no accept -> IDLE.
  - SECOND without m_ready -> hold. An accept (when !pend_v) writes pend.
- Latency: a row accepted at cycle t appears as FIRST at t+1 when the block is IDLE.
- Throughput: 1 input row per 2 cycles, with 100% output utilisation when s_valid=m_ready=1 continuously.
- AXI-style rules:
  - m_valid/m_data/m_dup never change while m_valid && !m_ready.
  - m_valid never depends combinationally on m_ready.
- Pixel values are never compared or modified. Width W is passed straight through.

Decomposition:
- Package types gains typedef enum type_upsample_state_t {IDLE, FIRST, SECOND}. Use a distinct name, since S1..S3 are already used by the max-pool enum.
- Sub-module pix_dup (combinational, parameters C and W): maps out_row to m_data. Keeps the top focused on FSM and buffering.
- The FSM, out_row and pending buffer stay in upsample_2x2.

Test Plan:
- Single row, C=2, W=8: after reset, s_data={8'h12,8'h34} ([1]=12,[0]=34), m_ready=1.
  - Expect cycle t+1: m_data={12,12,34,34}, m_dup=0.
  - Expect t+2: same data, m_dup=1.
  - Expect t+3: m_valid=0.
- Back-to-back: rows A=0x0102, B=0x0304, C=0x0506 with s_valid=m_ready=1.
  - Expect s_ready pattern 1,1,0,1,0,1.
  - Expect outputs A0,A1,B0,B1,C0,C1 on consecutive cycles with no gaps.
- Backpressure: hold m_ready=0 for 5 cycles during FIRST of row 0xAABB.
  - Expect m_data={AA,AA,BB,BB} and m_dup=0 to stay stable.
  - Expect the second row offered to be accepted into pend, then s_ready=0.
  - Release m_ready: expect correct order with no loss.
- Back-pressure in SECOND: pend full, m_ready toggles 0/1 every cycle.
  - Expect s_ready to rise only in the cycle after pend is drained.
  - Expect no duplicate or dropped beats; a scoreboard shows 2 output beats per input row.
- Reset mid-operation: assert rst during SECOND with pend_v=1.
  - Expect the next cycle m_valid=0, m_dup=0, m_data=0, s_ready=1 after rst deasserts.
  - Expect the pending row never to be emitted.
- Parameter sweep C=4, W=16: input {FFFF,0000,8001,7FFE}.
  - Expect output {FFFF,FFFF,0000,0000,8001,8001,7FFE,7FFE} on both beats, values unaltered.
